mu0_memory_responder: RTL and testbench

Memory-side responder for the MU0 datapath. Accepts one read or write request at a time on the 12-bit address bus driven by the MU0 address multiplexer. Services it from an internal 4K x 16 synchronous word store after a programmable number of wait states, then returns a one-cycle acknowledge with read data. Sits between the MU0 core's address/data paths and the system memory model, replacing the zero-latency combinational memory.

---
 rtl/mu0_mem_pkg.sv | 15 +
 rtl/mu0_mem_array.sv | 46 ++++
 rtl/mu0_memory_responder.sv | 106 ++++++++++
 tb/tb_mu0_memory_responder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mu0_mem_pkg.sv
// Shared definitions for the MU0 memory responder: state encoding, default widths
// and the wait-state counter width.
package mu0_mem_pkg;

    localparam int MU0_ADDR_W = 12;
    localparam int MU0_DATA_W = 16;
    localparam int MU0_CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } mu0_state_e;

endpackage

// File: rtl/mu0_mem_array.sv
// Single-port synchronous word store with write enable and a registered read port.
// Contents are never reset; only the read register clears so RdData starts at zero.
module mu0_mem_array
    import mu0_mem_pkg::*;
#(
    parameter int ADDR_W = MU0_ADDR_W,
    parameter int DATA_W = MU0_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] rdata_d;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // The read register only moves on a completed read, so writes leave it untouched.
    always_comb begin
        rdata_d = rdata_q;
        if (re) begin
            rdata_d = mem[addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/mu0_memory_responder.sv
// MU0 memory-side responder: captures one request, waits WAIT_CYCLES, performs the
// access on the internal store and pulses Ack for one cycle.
module mu0_memory_responder
    import mu0_mem_pkg::*;
#(
    parameter int ADDR_W      = MU0_ADDR_W,
    parameter int DATA_W      = MU0_DATA_W,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              nReset,
    input  logic              Req,
    input  logic              Wr,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] WrData,
    output logic              Ack,
    output logic [DATA_W-1:0] RdData,
    output logic              Busy
);

    localparam logic [MU0_CNT_W-1:0] WAIT_LOAD = MU0_CNT_W'(WAIT_CYCLES);

    mu0_state_e          state_q, state_d;
    logic [MU0_CNT_W-1:0] cnt_q, cnt_d;
    logic                wr_q, wr_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                ack_q, ack_d;
    logic                busy_q, busy_d;
    logic                mem_we;
    logic                mem_re;

    // Ternaries in IDLE let an unknown Req spread into the state rather than be masked.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = Req ? WAIT : IDLE;
                cnt_d   = Req ? WAIT_LOAD : cnt_q;
                wr_d    = Req ? Wr : wr_q;
                addr_d  = Req ? Addr : addr_q;
                wdata_d = Req ? WrData : wdata_q;
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    mem_we  = wr_q;
                    mem_re  = !wr_q;
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
        ack_d  = (state_d == RESP);
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
        end
    end

    mu0_mem_array #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_array (
        .clk  (Clk),
        .rst_n(nReset),
        .we   (mem_we),
        .re   (mem_re),
        .addr (addr_q),
        .wdata(wdata_q),
        .rdata(RdData)
    );

    assign Ack  = ack_q;
    assign Busy = busy_q;

endmodule

// File: tb/tb_mu0_memory_responder.sv
// Bench for mu0_memory_responder: two instances (2 and 0 wait states) checked against
// a word-level model of the store, the last read value and the Ack latency.
module tb_mu0_memory_responder;

    logic        clk;
    logic        n_reset;
    logic        req   [2];
    logic        wr    [2];
    logic [11:0] addr  [2];
    logic [15:0] wdata [2];
    logic        ack   [2];
    logic [15:0] rdata [2];
    logic        busy  [2];

    logic [15:0] mdl_mem [2][4096];
    bit          mdl_val [2][4096];
    logic [15:0] mdl_rd  [2];

    int errors;
    int checks;

    mu0_memory_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(2)) dut_w2 (
        .Clk(clk), .nReset(n_reset), .Req(req[0]), .Wr(wr[0]), .Addr(addr[0]),
        .WrData(wdata[0]), .Ack(ack[0]), .RdData(rdata[0]), .Busy(busy[0])
    );

    mu0_memory_responder #(.ADDR_W(12), .DATA_W(16), .WAIT_CYCLES(0)) dut_w0 (
        .Clk(clk), .nReset(n_reset), .Req(req[1]), .Wr(wr[1]), .Addr(addr[1]),
        .WrData(wdata[1]), .Ack(ack[1]), .RdData(rdata[1]), .Busy(busy[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int waits(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    // Ack is expected in cycle waits+2 after capture; Busy covers cycles 1..waits+2.
    task automatic run_txn(input int i, input bit is_wr, input logic [11:0] a,
                           input logic [15:0] d, input int junk, input string name);
        int          lat;
        logic [15:0] exp_before;
        logic [15:0] exp_after;
        logic [15:0] exp_rd;
        logic        exp_ack;
        logic        exp_busy;
        lat        = waits(i) + 2;
        exp_before = mdl_rd[i];
        exp_after  = is_wr ? exp_before : mdl_mem[i][a];
        @(negedge clk);
        req[i] = 1'b1; wr[i] = is_wr; addr[i] = a; wdata[i] = d;
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            exp_ack  = (k == lat);
            exp_busy = (k <= lat);
            exp_rd   = (k >= lat) ? exp_after : exp_before;
            checks++;
            if (ack[i] !== exp_ack) begin
                errors++;
                $display("[TB] FAIL %s ack cycle %0d: got %b want %b", name, k, ack[i], exp_ack);
            end
            checks++;
            if (busy[i] !== exp_busy) begin
                errors++;
                $display("[TB] FAIL %s busy cycle %0d: got %b want %b", name, k, busy[i], exp_busy);
            end
            checks++;
            if (rdata[i] !== exp_rd) begin
                errors++;
                $display("[TB] FAIL %s rddata cycle %0d: got %h want %h", name, k, rdata[i], exp_rd);
            end
            if (k == lat + 1 || junk == 0) begin
                req[i] = 1'b0;
            end else if (junk == 1) begin
                addr[i] = 12'h020;
                req[i]  = ~req[i];
                wr[i]   = ~wr[i];
            end else begin
                req[i]   = 1'($urandom);
                wr[i]    = 1'($urandom);
                addr[i]  = 12'($urandom);
                wdata[i] = 16'($urandom);
            end
        end
        if (is_wr) begin
            mdl_mem[i][a] = d;
            mdl_val[i][a] = 1'b1;
        end else begin
            mdl_rd[i] = exp_after;
        end
    endtask

    task automatic test_reset();
        n_reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req[i] = 1'b1; wr[i] = 1'($urandom); addr[i] = 12'h123; wdata[i] = 16'($urandom);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (ack[i] !== 1'b0 || busy[i] !== 1'b0 || rdata[i] !== 16'h0000) begin
                    errors++;
                    $display("[TB] FAIL reset inst%0d: ack=%b busy=%b rd=%h want 0 0 0000",
                             i, ack[i], busy[i], rdata[i]);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            req[i]    = 1'b0;
            mdl_rd[i] = 16'h0000;
        end
        n_reset = 1'b1;
    endtask

    task automatic test_write_read();
        run_txn(0, 1'b1, 12'h010, 16'hBEEF, 0, "write_beef");
        run_txn(0, 1'b0, 12'h010, 16'h0000, 0, "read_beef");
    endtask

    task automatic test_boundary();
        run_txn(0, 1'b1, 12'hFFF, 16'hFFFF, 0, "write_top");
        run_txn(0, 1'b1, 12'h000, 16'h0000, 0, "write_bottom");
        run_txn(0, 1'b0, 12'hFFF, 16'h0000, 0, "read_top");
        run_txn(0, 1'b0, 12'h000, 16'h0000, 0, "read_bottom");
        run_txn(0, 1'b0, 12'h010, 16'h0000, 0, "read_mid");
    endtask

    task automatic test_busy_masking();
        run_txn(0, 1'b0, 12'h010, 16'h0000, 1, "masked_read");
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL masking extra ack: ack=%b busy=%b want 0 0", ack[0], busy[0]);
            end
        end
    endtask

    // Req held high: the second capture happens in the first IDLE cycle after RESP.
    task automatic test_back_to_back();
        int          ack_cyc [$];
        logic [15:0] ack_dat [$];
        logic [15:0] exp1;
        logic [15:0] exp2;
        run_txn(1, 1'b1, 12'h010, 16'hBEEF, 0, "w0_write_beef");
        run_txn(1, 1'b1, 12'hFFF, 16'hFFFF, 0, "w0_write_top");
        exp1 = mdl_mem[1][12'h010];
        exp2 = mdl_mem[1][12'hFFF];
        @(negedge clk);
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 12'h010;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ack[1] === 1'b1) begin
                ack_cyc.push_back(k);
                ack_dat.push_back(rdata[1]);
            end
            if (k == 1) addr[1] = 12'hFFF;
            if (k == 4) req[1] = 1'b0;
        end
        checks++;
        if (ack_cyc.size() != 2) begin
            errors++;
            $display("[TB] FAIL b2b ack count: got %0d want 2", ack_cyc.size());
        end else begin
            checks++;
            if (ack_cyc[0] != waits(1) + 2) begin
                errors++;
                $display("[TB] FAIL b2b first ack: got cycle %0d want %0d", ack_cyc[0], waits(1) + 2);
            end
            checks++;
            if (ack_cyc[1] - ack_cyc[0] != 3) begin
                errors++;
                $display("[TB] FAIL b2b spacing: got %0d want 3", ack_cyc[1] - ack_cyc[0]);
            end
            checks++;
            if (ack_dat[0] !== exp1 || ack_dat[1] !== exp2) begin
                errors++;
                $display("[TB] FAIL b2b data: got %h %h want %h %h", ack_dat[0], ack_dat[1], exp1, exp2);
            end
        end
        mdl_rd[1] = exp2;
    endtask

    task automatic test_abort();
        @(negedge clk);
        req[0] = 1'b1; wr[0] = 1'b1; addr[0] = 12'h010; wdata[0] = 16'h1234;
        @(negedge clk);
        req[0] = 1'b0;
        #1 n_reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (ack[i] !== 1'b0 || busy[i] !== 1'b0 || rdata[i] !== 16'h0000) begin
                errors++;
                $display("[TB] FAIL abort async inst%0d: ack=%b busy=%b rd=%h want 0 0 0000",
                         i, ack[i], busy[i], rdata[i]);
            end
            mdl_rd[i] = 16'h0000;
        end
        @(negedge clk);
        n_reset = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (ack[0] !== 1'b0) begin
                errors++;
                $display("[TB] FAIL abort stray ack cycle %0d: got %b want 0", c, ack[0]);
            end
        end
        run_txn(0, 1'b0, 12'h010, 16'h0000, 0, "read_after_abort");
    endtask

    task automatic test_random();
        logic [11:0] pool [8];
        logic [11:0] a;
        int          i;
        bit          is_wr;
        pool = '{12'h010, 12'hFFF, 12'h000, 12'h5A5, 12'h7FE, 12'h001, 12'h800, 12'h3C3};
        for (int n = 0; n < 16; n++) begin
            i     = int'($urandom_range(0, 1));
            a     = pool[$urandom_range(0, 7)];
            is_wr = 1'($urandom);
            if (!mdl_val[i][a]) is_wr = 1'b1;
            run_txn(i, is_wr, a, 16'($urandom), 2, "random");
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_boundary();
        test_busy_masking();
        test_back_to_back();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
